// File: rtl/kk_round_feeder.sv
// kk_round_feeder: streams the 56-byte expanded key one round-key byte
// per valid/ready handshake, ascending for encipher, descending for decipher.
module kk_round_feeder #(
   parameter int NROUNDS = 56,
   parameter int KW      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NROUNDS*KW-1:0] i_kk,
   input  logic                  i_kk_valid,
   output logic                  o_kk_ready,
   input  logic                  i_dir,
   input  logic                  i_abort,
   output logic [KW-1:0]         o_rk,
   output logic                  o_rk_valid,
   input  logic                  i_rk_ready,
   output logic [5:0]            o_round,
   output logic                  o_last
);

   localparam logic [5:0] LAST_IDX = 6'(NROUNDS - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t                  state_q, state_d;
   logic [NROUNDS*KW-1:0]   kk_q, kk_d;
   logic                    dir_q, dir_d;
   logic [5:0]              idx_q, idx_d;
   logic [KW-1:0]           rk_q, rk_d;
   logic                    xfer;
   logic                    last;

   // Byte n of the stream: kk[n+1] ascending, kk[NROUNDS-n] descending.
   function automatic logic [KW-1:0] pick(
      input logic [NROUNDS*KW-1:0] kk,
      input logic                  dir,
      input logic [5:0]            n
   );
      logic [5:0] pos;
      pos = dir ? (LAST_IDX - n) : n;
      return kk[int'(pos)*KW +: KW];
   endfunction

   assign o_kk_ready = (state_q == IDLE);
   assign o_rk_valid = (state_q == RUN);
   assign last       = o_rk_valid && (idx_q == LAST_IDX);
   assign xfer       = o_rk_valid && i_rk_ready;
   assign o_last     = last;
   assign o_round    = idx_q;
   assign o_rk       = rk_q;

   // Next state: load in IDLE, advance/finish/abort in RUN.
   always_comb begin
      state_d = state_q;
      kk_d    = kk_q;
      dir_d   = dir_q;
      idx_d   = idx_q;
      rk_d    = rk_q;
      unique case (state_q)
         IDLE: begin
            if (i_kk_valid) begin
               state_d = RUN;
               kk_d    = i_kk;
               dir_d   = i_dir;
               idx_d   = '0;
               rk_d    = pick(i_kk, i_dir, 6'd0);
            end
         end
         RUN: begin
            if (i_abort || (xfer && last)) begin
               state_d = IDLE;
               idx_d   = '0;
               rk_d    = '0;
            end else if (xfer) begin
               idx_d = idx_q + 6'd1;
               rk_d  = pick(kk_q, dir_q, idx_q + 6'd1);
            end
         end
      endcase
   end

   // State, key, direction, counter and registered byte mux.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         kk_q    <= '0;
         dir_q   <= 1'b0;
         idx_q   <= '0;
         rk_q    <= '0;
      end else begin
         state_q <= state_d;
         kk_q    <= kk_d;
         dir_q   <= dir_d;
         idx_q   <= idx_d;
         rk_q    <= rk_d;
      end
   end

endmodule

// File: tb/tb_kk_round_feeder.sv
// tb_kk_round_feeder: scenario tasks plus randomized traffic, checked
// against a queue-of-bytes reference model of the round-key stream.
module tb_kk_round_feeder;

   localparam int NR = 56;
   localparam int KW = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NR*KW-1:0] i_kk = '0;
   logic             i_kk_valid = 1'b0;
   logic             i_dir = 1'b0;
   logic             i_abort = 1'b0;
   logic             i_rk_ready = 1'b1;
   logic             o_kk_ready;
   logic             o_rk_valid;
   logic             o_last;
   logic [7:0]       o_rk;
   logic [5:0]       o_round;

   kk_round_feeder #(.NROUNDS(NR), .KW(KW)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_kk       (i_kk),
      .i_kk_valid (i_kk_valid),
      .o_kk_ready (o_kk_ready),
      .i_dir      (i_dir),
      .i_abort    (i_abort),
      .o_rk       (o_rk),
      .o_rk_valid (o_rk_valid),
      .i_rk_ready (i_rk_ready),
      .o_round    (o_round),
      .o_last     (o_last)
   );

   always #5 clk = ~clk;

   int vec  = 0;
   int miss = 0;

   // reference model: the pending byte list and a position into it
   logic [7:0] m_seq[$];
   bit         m_busy = 0;
   int         m_pos  = 0;

   function automatic logic [NR*KW-1:0] seq_kk();
      logic [NR*KW-1:0] k;
      for (int r = 1; r <= NR; r++) k[r*8-1 -: 8] = 8'(r);
      return k;
   endfunction

   function automatic logic [NR*KW-1:0] rand_kk();
      logic [NR*KW-1:0] k;
      for (int r = 1; r <= NR; r++) k[r*8-1 -: 8] = 8'($urandom);
      return k;
   endfunction

   function automatic logic [8:0] e_ctrl();
      return {!m_busy, m_busy, m_busy ? 6'(m_pos) : 6'd0,
              m_busy && (m_pos == NR - 1)};
   endfunction

   function automatic logic [7:0] e_rk();
      return m_seq[m_pos];
   endfunction

   // advance one clock, updating the model from the inputs seen at the edge
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_busy = 0;
         m_pos  = 0;
      end else if (!m_busy) begin
         if (i_kk_valid) begin
            m_seq.delete();
            for (int n = 0; n < NR; n++) begin
               int r;
               r = i_dir ? NR - n : n + 1;
               m_seq.push_back(i_kk[r*8-1 -: 8]);
            end
            m_busy = 1;
            m_pos  = 0;
         end
      end else if (i_abort) begin
         m_busy = 0;
         m_pos  = 0;
      end else if (i_rk_ready) begin
         m_pos++;
         if (m_pos == NR) begin
            m_busy = 0;
            m_pos  = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic load(input logic [NR*KW-1:0] k, input logic d);
      i_kk = k;
      i_dir = d;
      i_kk_valid = 1'b1;
      tick();
      i_kk_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_kk = rand_kk();
      i_kk_valid = 1'b1;
      tick();
      rst = 1'b0;
      i_kk_valid = 1'b0;
      vec++;
      if ({o_kk_ready, o_rk_valid, o_rk, o_round, o_last} !==
          {1'b1, 1'b0, 8'h00, 6'd0, 1'b0}) begin
         miss++;
         $display("FAIL reset: got rdy%b v%b rk%h rnd%0d last%b want 1 0 00 0 0",
                  o_kk_ready, o_rk_valid, o_rk, o_round, o_last);
      end
   endtask

   task automatic test_ascending();
      i_rk_ready = 1'b1;
      load(seq_kk(), 1'b0);
      for (int k = 0; k < NR; k++) begin
         vec++;
         if (o_rk_valid !== 1'b1 || o_rk !== 8'(k + 1) ||
             o_round !== 6'(k) || o_last !== (k == NR - 1)) begin
            miss++;
            $display("FAIL asc k=%0d: got v%b rk%h rnd%0d last%b want 1 %h %0d %b",
                     k, o_rk_valid, o_rk, o_round, o_last, 8'(k + 1), k, k == NR - 1);
         end
         tick();
      end
      vec++;
      if (o_kk_ready !== 1'b1 || o_rk_valid !== 1'b0 || o_round !== 6'd0 || o_last !== 1'b0) begin
         miss++;
         $display("FAIL asc_end: got rdy%b v%b rnd%0d last%b want 1 0 0 0",
                  o_kk_ready, o_rk_valid, o_round, o_last);
      end
   endtask

   task automatic test_descending();
      i_rk_ready = 1'b1;
      load(seq_kk(), 1'b1);
      for (int k = 0; k < NR; k++) begin
         vec++;
         if (o_rk_valid !== 1'b1 || o_rk !== 8'(NR - k) ||
             o_round !== 6'(k) || o_last !== (k == NR - 1)) begin
            miss++;
            $display("FAIL desc k=%0d: got v%b rk%h rnd%0d last%b want 1 %h %0d %b",
                     k, o_rk_valid, o_rk, o_round, o_last, 8'(NR - k), k, k == NR - 1);
         end
         tick();
      end
      vec++;
      if (o_kk_ready !== 1'b1 || o_rk_valid !== 1'b0) begin
         miss++;
         $display("FAIL desc_end: got rdy%b v%b want 1 0", o_kk_ready, o_rk_valid);
      end
   endtask

   task automatic test_stall();
      int stalled = 0;
      int xfers = 0;
      load(seq_kk(), 1'b0);
      for (int c = 0; c < 200 && m_busy; c++) begin
         i_rk_ready = !(m_pos == 10 && stalled < 3);
         if (!i_rk_ready) begin
            stalled++;
            vec++;
            if (o_rk_valid !== 1'b1 || o_rk !== 8'h0B || o_round !== 6'd10) begin
               miss++;
               $display("FAIL stall_hold: got v%b rk%h rnd%0d want 1 0b 10",
                        o_rk_valid, o_rk, o_round);
            end
         end
         vec++;
         if ({o_kk_ready, o_rk_valid, o_round, o_last} !== e_ctrl() ||
             (m_busy && o_rk !== e_rk())) begin
            miss++;
            $display("FAIL stall: got ctrl %b rk %h want ctrl %b rk %h",
                     {o_kk_ready, o_rk_valid, o_round, o_last}, o_rk, e_ctrl(), e_rk());
         end
         if (o_rk_valid && i_rk_ready) xfers++;
         tick();
      end
      i_rk_ready = 1'b1;
      vec++;
      if (xfers !== NR || stalled !== 3 || m_busy) begin
         miss++;
         $display("FAIL stall_count: got xfers %0d stalls %0d want %0d 3", xfers, stalled, NR);
      end
   endtask

   task automatic test_ignore_load();
      bit pulsed = 0;
      load(rand_kk(), 1'($urandom));
      for (int c = 0; c < 200 && m_busy; c++) begin
         i_kk_valid = (m_pos == 5 && !pulsed);
         if (i_kk_valid) begin
            pulsed = 1;
            i_kk = rand_kk();
            i_dir = ~i_dir;
         end
         vec++;
         if ({o_kk_ready, o_rk_valid, o_round, o_last} !== e_ctrl() ||
             (m_busy && o_rk !== e_rk())) begin
            miss++;
            $display("FAIL ignore: got ctrl %b rk %h want ctrl %b rk %h",
                     {o_kk_ready, o_rk_valid, o_round, o_last}, o_rk, e_ctrl(), e_rk());
         end
         tick();
      end
      i_kk_valid = 1'b0;
      vec++;
      if (m_busy || o_kk_ready !== 1'b1) begin
         miss++;
         $display("FAIL ignore_end: got rdy%b want 1", o_kk_ready);
      end
   endtask

   task automatic test_abort();
      load(rand_kk(), 1'b0);
      for (int c = 0; c < 100 && m_busy; c++) begin
         i_abort = (m_pos == 20);
         vec++;
         if ({o_kk_ready, o_rk_valid, o_round, o_last} !== e_ctrl() ||
             (m_busy && o_rk !== e_rk())) begin
            miss++;
            $display("FAIL abort: got ctrl %b rk %h want ctrl %b rk %h",
                     {o_kk_ready, o_rk_valid, o_round, o_last}, o_rk, e_ctrl(), e_rk());
         end
         tick();
      end
      i_abort = 1'b0;
      vec++;
      if (o_rk_valid !== 1'b0 || o_kk_ready !== 1'b1 || o_round !== 6'd0) begin
         miss++;
         $display("FAIL abort_idle: got v%b rdy%b rnd%0d want 0 1 0",
                  o_rk_valid, o_kk_ready, o_round);
      end
      // abort while idle must not block a concurrent load
      i_abort = 1'b1;
      load(seq_kk(), 1'b1);
      i_abort = 1'b0;
      vec++;
      if (o_rk_valid !== 1'b1 || o_rk !== 8'h38 || o_round !== 6'd0) begin
         miss++;
         $display("FAIL abort_reload: got v%b rk%h rnd%0d want 1 38 0",
                  o_rk_valid, o_rk, o_round);
      end
      for (int c = 0; c < 200 && m_busy; c++) begin
         i_rk_ready = 1'($urandom_range(0, 3) != 0);
         vec++;
         if ({o_kk_ready, o_rk_valid, o_round, o_last} !== e_ctrl() ||
             (m_busy && o_rk !== e_rk())) begin
            miss++;
            $display("FAIL abort_run: got ctrl %b rk %h want ctrl %b rk %h",
                     {o_kk_ready, o_rk_valid, o_round, o_last}, o_rk, e_ctrl(), e_rk());
         end
         tick();
      end
      i_rk_ready = 1'b1;
      vec++;
      if (m_busy) begin
         miss++;
         $display("FAIL abort_timeout: got busy at pos %0d want idle", m_pos);
      end
   endtask

   task automatic test_reset_mid();
      load(rand_kk(), 1'($urandom));
      for (int c = 0; c < 100 && m_busy && m_pos < 30; c++) begin
         vec++;
         if ({o_kk_ready, o_rk_valid, o_round, o_last} !== e_ctrl() ||
             (m_busy && o_rk !== e_rk())) begin
            miss++;
            $display("FAIL rstmid: got ctrl %b rk %h want ctrl %b rk %h",
                     {o_kk_ready, o_rk_valid, o_round, o_last}, o_rk, e_ctrl(), e_rk());
         end
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vec++;
      if ({o_kk_ready, o_rk_valid, o_rk, o_round, o_last} !==
          {1'b1, 1'b0, 8'h00, 6'd0, 1'b0}) begin
         miss++;
         $display("FAIL rstmid_vals: got rdy%b v%b rk%h rnd%0d last%b want 1 0 00 0 0",
                  o_kk_ready, o_rk_valid, o_rk, o_round, o_last);
      end
      load(rand_kk(), 1'($urandom));
      for (int c = 0; c < 300 && m_busy; c++) begin
         i_rk_ready = 1'($urandom_range(0, 2) != 0);
         vec++;
         if ({o_kk_ready, o_rk_valid, o_round, o_last} !== e_ctrl() ||
             (m_busy && o_rk !== e_rk())) begin
            miss++;
            $display("FAIL rstmid_run: got ctrl %b rk %h want ctrl %b rk %h",
                     {o_kk_ready, o_rk_valid, o_round, o_last}, o_rk, e_ctrl(), e_rk());
         end
         tick();
      end
      i_rk_ready = 1'b1;
      vec++;
      if (m_busy) begin
         miss++;
         $display("FAIL rstmid_timeout: got busy at pos %0d want idle", m_pos);
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 4000; c++) begin
         i_kk_valid = 1'($urandom_range(0, 1));
         i_kk       = rand_kk();
         i_dir      = 1'($urandom);
         i_rk_ready = 1'($urandom_range(0, 3) != 0);
         i_abort    = ($urandom_range(0, 63) == 0);
         rst        = ($urandom_range(0, 499) == 0);
         vec++;
         if ({o_kk_ready, o_rk_valid, o_round, o_last} !== e_ctrl() ||
             (m_busy && o_rk !== e_rk())) begin
            miss++;
            $display("FAIL random c=%0d: got ctrl %b rk %h want ctrl %b rk %h",
                     c, {o_kk_ready, o_rk_valid, o_round, o_last}, o_rk, e_ctrl(), e_rk());
         end
         tick();
      end
      rst = 1'b0;
      i_kk_valid = 1'b0;
      i_abort = 1'b0;
      i_rk_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_ascending();
      test_descending();
      test_stall();
      test_ignore_load();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
